// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among NUM_REQ byte-stream requesters with
//   frame-locked round-robin arbitration. Once a requester is granted it keeps
//   the UART until the byte it flagged as last has finished, so frames never
//   interleave. A per-state watchdog releases the UART if the owner or the
//   UART stalls.
//
// Ports
//   clk_i          system clock, rising edge
//   reset_i        synchronous active-high reset
//   req_valid_i    requester i presents a byte
//   req_byte_i     byte of requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last_i     presented byte closes requester i's frame
//   req_ready_o    1-cycle pulse: byte of requester i accepted
//   grant_o        one-hot current owner, zero when idle
//   busy_o         a frame is in progress
//   tx_drive_o     1-cycle pulse: UART starts tx_byte_in_o
//   tx_byte_in_o   byte to the UART, stable until the next tx_drive_o
//   tx_active_i    UART is shifting a byte
//   tx_done_i      1-cycle pulse: UART byte finished
//   timeout_err_o  sticky watchdog abort flag, cleared only by reset
//
// state   | meaning
// IDLE    | no owner, arbitrating among valid requesters
// LOAD    | owner granted, waiting for its byte and a free UART
// WAIT    | byte handed to the UART, waiting for tx_done_i
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_byte_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          tx_drive_o,
  output logic [DATA_WIDTH-1:0]         tx_byte_in_o,
  input  logic                          tx_active_i,
  input  logic                          tx_done_i,
  output logic                          timeout_err_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]        gidx_q, gidx_d;
  logic [IDX_W-1:0]        rr_q, rr_d;
  logic                    busy_q, busy_d;
  logic [NUM_REQ-1:0]      ready_q, ready_d;
  logic                    drive_q, drive_d;
  logic [DATA_WIDTH-1:0]   byte_q, byte_d;
  logic                    last_q, last_d;
  logic                    terr_q, terr_d;
  logic [WD_W-1:0]         wdog_q, wdog_d;

  logic [DATA_WIDTH-1:0]   byte_arr [NUM_REQ];
  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_idx;
  logic [IDX_W-1:0]        cand;
  logic                    release_frame;
  logic                    wd_expired;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign byte_arr[i] = req_byte_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin scan starts just after the last owner and wraps.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_q) + k) % NUM_REQ);
      if (!pick_valid && req_valid_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign wd_expired = (wdog_q == WD_LIMIT);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    rr_d          = rr_q;
    busy_d        = busy_q;
    ready_d       = '0;
    drive_d       = 1'b0;
    byte_d        = byte_q;
    last_d        = last_q;
    terr_d        = terr_q;
    release_frame = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = NUM_REQ'(1) << pick_idx;
          gidx_d  = pick_idx;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Progress beats a watchdog expiry on the same edge.
        if (req_valid_i[gidx_q] && !tx_active_i) begin
          byte_d  = byte_arr[gidx_q];
          last_d  = req_last_i[gidx_q];
          drive_d = 1'b1;
          ready_d = grant_q;
          state_d = ST_WAIT;
        end else if (wd_expired) begin
          terr_d        = 1'b1;
          release_frame = 1'b1;
        end
      end
      ST_WAIT: begin
        if (tx_done_i) begin
          if (last_q) release_frame = 1'b1;
          else        state_d       = ST_LOAD;
        end else if (wd_expired) begin
          terr_d        = 1'b1;
          release_frame = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (release_frame) begin
      grant_d = '0;
      busy_d  = 1'b0;
      rr_d    = gidx_q;
      state_d = ST_IDLE;
    end

    // Every exit from LOAD/WAIT is a state change, so the count never wraps.
    if (state_d != state_q)     wdog_d = '0;
    else if (state_q != ST_IDLE) wdog_d = wdog_q + WD_W'(1);
    else                        wdog_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= IDX_W'(NUM_REQ - 1);
      busy_q  <= 1'b0;
      ready_q <= '0;
      drive_q <= 1'b0;
      byte_q  <= '0;
      last_q  <= 1'b0;
      terr_q  <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      drive_q <= drive_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      terr_q  <= terr_d;
      wdog_q  <= wdog_d;
    end
  end

  assign grant_o       = grant_q;
  assign busy_o        = busy_q;
  assign req_ready_o   = ready_q;
  assign tx_drive_o    = drive_q;
  assign tx_byte_in_o  = byte_q;
  assign timeout_err_o = terr_q;

endmodule
